// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer.
`timescale 1ns/1ps
package pc_seq_pkg;
    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_ISSUE
    } state_t;
endpackage

// File: rtl/pc_sequencer_pc_reg.sv
// PC register: synchronous reset to a parameterised vector, load enable.
`timescale 1ns/1ps
module pc_reg
    import pc_seq_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VALUE = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [PC_W-1:0] d,
    output logic [PC_W-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else if (load) begin
            q <= d;
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: fetch FSM, next-PC priority mux and pending trap redirect.
// Optional target alignment check: define PC_SEQ_ALIGN_CHECK_EN.
`timescale 1ns/1ps
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [PC_W-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            stall_i,
    input  logic            branch_taken_i,
    input  logic [PC_W-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [PC_W-1:0] jump_target_i,
    input  logic            trap_i,
    output logic            imem_req_o,
    output logic [PC_W-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    output logic            instr_valid_o,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] pc_plus4_o
`ifdef PC_SEQ_ALIGN_CHECK_EN
   ,output logic            misalign_o
`endif
);
    state_t          state;
    logic            pend_q;
    logic [PC_W-1:0] pend_tgt_q;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_d;
    logic            pc_load;
    logic            tgt_sel;
    logic [PC_W-1:0] tgt_raw;
    logic [PC_W-1:0] tgt;
    logic [PC_W-1:0] next_pc;
    logic            advance;
`ifdef PC_SEQ_ALIGN_CHECK_EN
    logic            tgt_bad;
`endif

    pc_reg #(
        .RESET_VALUE(RESET_VECTOR)
    ) u_pc_reg (
        .clk  (clk_i),
        .reset(reset_i),
        .load (pc_load),
        .d    (pc_d),
        .q    (pc)
    );

    assign pc_o        = pc;
    assign imem_addr_o = pc;
    assign pc_plus4_o  = pc + PC_STEP;

    // Jump outranks branch when both resolve in the same cycle.
    always_comb begin
        tgt_sel = jump_i | branch_taken_i;
        tgt_raw = jump_i ? jump_target_i : branch_target_i;
`ifdef PC_SEQ_ALIGN_CHECK_EN
        tgt_bad = tgt_sel && (tgt_raw[1:0] != 2'b00);
        tgt     = tgt_bad ? TRAP_VECTOR : tgt_raw;
`else
        tgt     = tgt_raw & ~32'h0000_0003;
`endif
        if (trap_i) begin
            next_pc = TRAP_VECTOR;
        end else if (tgt_sel) begin
            next_pc = tgt;
        end else begin
            next_pc = pc_plus4_o;
        end
    end

    assign advance = !stall_i || trap_i;

    always_comb begin
        pc_load = 1'b0;
        pc_d    = next_pc;
        unique case (state)
            S_REQ: begin
                if (imem_ack_i && (pend_q || trap_i)) begin
                    pc_load = 1'b1;
                    pc_d    = trap_i ? TRAP_VECTOR : pend_tgt_q;
                end
            end
            S_ISSUE: begin
                pc_load = advance;
            end
            default: begin
                pc_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state         <= S_BOOT;
            imem_req_o    <= 1'b0;
            instr_valid_o <= 1'b0;
            pend_q        <= 1'b0;
            pend_tgt_q    <= RESET_VECTOR;
`ifdef PC_SEQ_ALIGN_CHECK_EN
            misalign_o    <= 1'b0;
`endif
        end else begin
`ifdef PC_SEQ_ALIGN_CHECK_EN
            misalign_o <= 1'b0;
`endif
            unique case (state)
                S_BOOT: begin
                    state      <= S_REQ;
                    imem_req_o <= 1'b1;
                end
                S_REQ: begin
                    if (trap_i) begin
                        pend_q     <= 1'b1;
                        pend_tgt_q <= TRAP_VECTOR;
                    end
                    // A redirected fetch is dropped and re-requested.
                    if (imem_ack_i) begin
                        if (pend_q || trap_i) begin
                            pend_q <= 1'b0;
                        end else begin
                            state         <= S_ISSUE;
                            imem_req_o    <= 1'b0;
                            instr_valid_o <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (advance) begin
                        state         <= S_REQ;
                        imem_req_o    <= 1'b1;
                        instr_valid_o <= 1'b0;
`ifdef PC_SEQ_ALIGN_CHECK_EN
                        misalign_o    <= !trap_i && tgt_bad;
`endif
                    end
                end
                default: begin
                    state         <= S_BOOT;
                    imem_req_o    <= 1'b0;
                    instr_valid_o <= 1'b0;
                end
            endcase
        end
    end
endmodule
